// File: rtl/core_axi_pkg.sv
// Shared encodings for the AXI4-Lite memory arbiter: FSM states, response codes
// and master index constants.
package core_axi_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

endpackage

// File: rtl/core_arb_select.sv
// Two-request read arbiter. Fixed priority M1 > M0 by default; round-robin with a
// last-served pointer when ARB_ROUND_ROBIN_EN is defined.
module core_arb_select
  import core_axi_pkg::*;
(
  input  logic CLK,
  input  logic NRST,
  input  logic req_m0,
  input  logic req_m1,
  input  logic done,
  input  logic done_idx,
  output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_idx;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      last_idx <= M0_IDX;
    end else if (done) begin
      last_idx <= done_idx;
    end
  end

  // On a tie the master that was not served last wins
  always_comb begin
    winner = M1_IDX;
    if (req_m0 && req_m1) begin
      winner = (last_idx == M1_IDX) ? M0_IDX : M1_IDX;
    end else if (req_m0) begin
      winner = M0_IDX;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{CLK, NRST, done, done_idx};
  assign winner    = (req_m1 || !req_m0) ? M1_IDX : M0_IDX;
`endif

endmodule

// File: rtl/core_axil_mem_arbiter.sv
// Shares one AXI4-Lite memory slave between instruction fetch (M0, read-only) and
// the LSU (M1, read/write). Define ARB_ROUND_ROBIN_EN for round-robin read arbitration.
module core_axil_mem_arbiter
  import core_axi_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   M0_ARADDR,
  input  logic                    M0_ARVALID,
  output logic                    M0_ARREADY,
  output logic [AXI_DWIDTH-1:0]   M0_RDATA,
  output logic [1:0]              M0_RRESP,
  output logic                    M0_RVALID,
  input  logic                    M0_RREADY,
  input  logic [AXI_AWIDTH-1:0]   M1_ARADDR,
  input  logic                    M1_ARVALID,
  output logic                    M1_ARREADY,
  output logic [AXI_DWIDTH-1:0]   M1_RDATA,
  output logic [1:0]              M1_RRESP,
  output logic                    M1_RVALID,
  input  logic                    M1_RREADY,
  input  logic [AXI_AWIDTH-1:0]   M1_AWADDR,
  input  logic                    M1_AWVALID,
  output logic                    M1_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   M1_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] M1_WSTRB,
  input  logic                    M1_WVALID,
  output logic                    M1_WREADY,
  output logic [1:0]              M1_BRESP,
  output logic                    M1_BVALID,
  input  logic                    M1_BREADY,
  output logic [AXI_AWIDTH-1:0]   S_ARADDR,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   S_RDATA,
  input  logic [1:0]              S_RRESP,
  input  logic                    S_RVALID,
  output logic                    S_RREADY,
  output logic [AXI_AWIDTH-1:0]   S_AWADDR,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [AXI_DWIDTH-1:0]   S_WDATA,
  output logic [AXI_DWIDTH/8-1:0] S_WSTRB,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  input  logic [1:0]              S_BRESP,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  output logic                    GNT_M1
);

  rd_state_e rd_state, rd_next;
  wr_state_e wr_state, wr_next;
  logic      grant, arb_winner, rd_done;
  logic      aw_done, w_done, aw_hs, w_hs, b_hs;

  core_arb_select u_arb_select (
    .CLK      (CLK),
    .NRST     (NRST),
    .req_m0   (M0_ARVALID),
    .req_m1   (M1_ARVALID),
    .done     (rd_done),
    .done_idx (grant),
    .winner   (arb_winner)
  );

  // Grant only moves in RD_IDLE, so it is stable for a whole transaction
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rd_state <= RD_IDLE;
      grant    <= M0_IDX;
    end else begin
      rd_state <= rd_next;
      if (rd_state == RD_IDLE && (M0_ARVALID || M1_ARVALID)) begin
        grant <= arb_winner;
      end
    end
  end

  always_comb begin
    rd_next    = rd_state;
    rd_done    = 1'b0;
    S_ARADDR   = (grant == M1_IDX) ? M1_ARADDR : M0_ARADDR;
    S_ARVALID  = 1'b0;
    S_RREADY   = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    M0_RVALID  = 1'b0;
    M1_RVALID  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (M0_ARVALID || M1_ARVALID) rd_next = RD_ADDR;
      end
      RD_ADDR: begin
        if (grant == M1_IDX) begin
          S_ARVALID  = M1_ARVALID;
          M1_ARREADY = S_ARREADY;
        end else begin
          S_ARVALID  = M0_ARVALID;
          M0_ARREADY = S_ARREADY;
        end
        if (S_ARVALID && S_ARREADY) rd_next = RD_DATA;
      end
      RD_DATA: begin
        if (grant == M1_IDX) begin
          M1_RVALID = S_RVALID;
          S_RREADY  = M1_RREADY;
        end else begin
          M0_RVALID = S_RVALID;
          S_RREADY  = M0_RREADY;
        end
        if (S_RVALID && S_RREADY) begin
          rd_done = 1'b1;
          rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign M0_RDATA = S_RDATA;
  assign M0_RRESP = S_RRESP;
  assign M1_RDATA = S_RDATA;
  assign M1_RRESP = S_RRESP;
  assign GNT_M1   = (rd_state != RD_IDLE) && (grant == M1_IDX);

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // AW and W complete independently; a finished channel is masked until B returns
  always_comb begin
    wr_next    = wr_state;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    b_hs       = 1'b0;
    S_AWVALID  = 1'b0;
    S_WVALID   = 1'b0;
    S_BREADY   = 1'b0;
    M1_AWREADY = 1'b0;
    M1_WREADY  = 1'b0;
    M1_BVALID  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (M1_AWVALID || M1_WVALID) wr_next = WR_REQ;
      end
      WR_REQ: begin
        S_AWVALID  = M1_AWVALID && !aw_done;
        M1_AWREADY = S_AWREADY && !aw_done;
        S_WVALID   = M1_WVALID && !w_done;
        M1_WREADY  = S_WREADY && !w_done;
        aw_hs      = S_AWVALID && S_AWREADY;
        w_hs       = S_WVALID && S_WREADY;
        if ((aw_done || aw_hs) && (w_done || w_hs)) wr_next = WR_RESP;
      end
      WR_RESP: begin
        M1_BVALID = S_BVALID;
        S_BREADY  = M1_BREADY;
        b_hs      = S_BVALID && M1_BREADY;
        if (b_hs) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign S_AWADDR = M1_AWADDR;
  assign S_WDATA  = M1_WDATA;
  assign S_WSTRB  = M1_WSTRB;
  assign M1_BRESP = S_BRESP;

endmodule

// File: tb/tb_core_axil_mem_arbiter.sv
// Randomized self-checking bench for core_axil_mem_arbiter with a behavioural slave
// whose data/response are pure functions of the address.
module tb_core_axil_mem_arbiter;
  import core_axi_pkg::*;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [31:0] M0_ARADDR, M1_ARADDR, M1_AWADDR, M1_WDATA;
  logic        M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RREADY;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [1:0]  M0_RRESP, M1_RRESP, M1_BRESP;
  logic        M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RREADY;
  logic        M1_AWVALID, M1_AWREADY, M1_WVALID, M1_WREADY, M1_BVALID, M1_BREADY;
  logic [3:0]  M1_WSTRB, S_WSTRB;
  logic [31:0] S_ARADDR, S_RDATA, S_AWADDR, S_WDATA;
  logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic [1:0]  S_RRESP, S_BRESP;
  logic        GNT_M1;

  int compared = 0, mismatched = 0;
  int arCount = 0, arIssued = 0, awCount = 0, wCount = 0, writesIssued = 0;
  logic monOn = 1'b0, m0InR = 1'b0, m1InR = 1'b0, m1InB = 1'b0;
  logic [31:0] wrExpAddr = '0, wrExpData = '0;
  logic [3:0]  wrExpStrb = '0;
  logic        order[$];

  core_axil_mem_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .CLK(CLK), .NRST(NRST),
    .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .GNT_M1(GNT_M1)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] memFunc(input logic [31:0] addr);
    if (addr == 32'h100) return 32'h0000_0013;
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [1:0] respFunc(input logic [31:0] addr);
    if (addr[6:4] == 3'b101) return AXI_RESP_SLVERR;
    if (addr[6:4] == 3'b110) return AXI_RESP_DECERR;
    return AXI_RESP_OKAY;
  endfunction

  function automatic logic [12:0] handshakeOutputs();
    return {M0_ARREADY, M0_RVALID, M1_ARREADY, M1_RVALID, M1_AWREADY, M1_WREADY, M1_BVALID,
            S_ARVALID, S_RREADY, S_AWVALID, S_WVALID, S_BREADY, GNT_M1};
  endfunction

  // Slave read side: one outstanding read, data appears after 0-3 cycles
  initial begin : slaveRead
    logic rst, arHs, rHs, pending;
    logic [31:0] addr;
    int dly;
    S_ARREADY = 0; S_RVALID = 0; S_RDATA = '0; S_RRESP = '0;
    pending = 0; addr = '0; dly = 0;
    forever begin
      @(negedge CLK);
      rst  = !NRST;
      arHs = S_ARVALID && S_ARREADY;
      rHs  = S_RVALID && S_RREADY;
      if (arHs) addr = S_ARADDR;
      @(posedge CLK); #1;
      if (rst) begin
        pending = 0; S_ARREADY = 0; S_RVALID = 0;
      end else begin
        if (rHs) begin S_RVALID = 0; pending = 0; end
        if (arHs) begin arCount++; pending = 1; dly = $urandom_range(0, 3); end
        if (pending && !S_RVALID) begin
          if (dly == 0) begin
            S_RVALID = 1; S_RDATA = memFunc(addr); S_RRESP = respFunc(addr);
          end else dly--;
        end
        S_ARREADY = !pending && ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Slave write side: collects AW and W in any order, then answers with one B
  initial begin : slaveWrite
    logic rst, awHs, wHs, bHs, gotAw, gotW, bPend;
    logic [31:0] addr;
    int dly;
    S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_BRESP = '0;
    gotAw = 0; gotW = 0; bPend = 0; addr = '0; dly = 0;
    forever begin
      @(negedge CLK);
      rst  = !NRST;
      awHs = S_AWVALID && S_AWREADY;
      wHs  = S_WVALID && S_WREADY;
      bHs  = S_BVALID && S_BREADY;
      if (!rst && awHs) begin
        checkOutput("S_AWADDR", S_AWADDR, wrExpAddr);
        addr = S_AWADDR;
      end
      if (!rst && wHs) begin
        checkOutput("S_WDATA", S_WDATA, wrExpData);
        checkOutput("S_WSTRB", {28'b0, S_WSTRB}, {28'b0, wrExpStrb});
      end
      @(posedge CLK); #1;
      if (rst) begin
        gotAw = 0; gotW = 0; bPend = 0; S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0;
      end else begin
        if (bHs) begin S_BVALID = 0; gotAw = 0; gotW = 0; bPend = 0; end
        if (awHs) begin awCount++; gotAw = 1; end
        if (wHs) begin wCount++; gotW = 1; end
        if (gotAw && gotW && !bPend) begin
          bPend = 1; dly = $urandom_range(0, 3);
        end else if (bPend && !S_BVALID) begin
          if (dly == 0) begin S_BVALID = 1; S_BRESP = respFunc(addr); end
          else dly--;
        end
        S_AWREADY = !gotAw && ($urandom_range(0, 2) != 0);
        S_WREADY  = !gotW && ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Responses must only reach a master that is waiting for one
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (monOn) begin
        checkOutput("M0_RVALID stray", {31'b0, M0_RVALID && !m0InR}, 32'd0);
        checkOutput("M1_RVALID stray", {31'b0, M1_RVALID && !m1InR}, 32'd0);
        checkOutput("M1_BVALID stray", {31'b0, M1_BVALID && !m1InB}, 32'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1
  task automatic readMaster(input logic idx, input logic [31:0] addr);
    logic ok, rr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    ok = 0;
    if (idx) begin M1_ARADDR = addr; M1_ARVALID = 1; end
    else     begin M0_ARADDR = addr; M0_ARVALID = 1; end
    for (int b = 0; b < 600 && !ok; b++) begin
      @(negedge CLK);
      ok = idx ? M1_ARREADY : M0_ARREADY;
    end
    checkOutput(idx ? "M1 AR handshake" : "M0 AR handshake", {31'b0, ok}, 32'd1);
    @(posedge CLK); #1;
    if (idx) M1_ARVALID = 0; else M0_ARVALID = 0;
    if (!ok) return;
    arIssued++;
    if (idx) m1InR = 1; else m0InR = 1;
    ok = 0;
    for (int b = 0; b < 600 && !ok; b++) begin
      rr = ($urandom_range(0, 3) != 0);
      if (idx) M1_RREADY = rr; else M0_RREADY = rr;
      @(negedge CLK);
      ok = idx ? (M1_RVALID && M1_RREADY) : (M0_RVALID && M0_RREADY);
      if (!ok) begin @(posedge CLK); #1; end
    end
    checkOutput(idx ? "M1 R handshake" : "M0 R handshake", {31'b0, ok}, 32'd1);
    if (ok) begin
      rdata = idx ? M1_RDATA : M0_RDATA;
      rresp = idx ? M1_RRESP : M0_RRESP;
      checkOutput(idx ? "M1_RDATA" : "M0_RDATA", rdata, memFunc(addr));
      checkOutput(idx ? "M1_RRESP" : "M0_RRESP", {30'b0, rresp}, {30'b0, respFunc(addr)});
      @(posedge CLK); #1;
      order.push_back(idx);
    end
    if (idx) begin M1_RREADY = 0; m1InR = 0; end
    else     begin M0_RREADY = 0; m0InR = 0; end
  endtask

  task automatic writeM1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awDly, input int wDly);
    logic awOk, wOk, ok;
    awOk = 0; wOk = 0; ok = 0;
    wrExpAddr = addr; wrExpData = data; wrExpStrb = strb; m1InB = 1;
    fork
      begin
        if (awDly > 0) begin repeat (awDly) @(posedge CLK); #1; end
        M1_AWADDR = addr; M1_AWVALID = 1;
        for (int b = 0; b < 600 && !awOk; b++) begin @(negedge CLK); awOk = M1_AWREADY; end
        @(posedge CLK); #1; M1_AWVALID = 0;
      end
      begin
        if (wDly > 0) begin repeat (wDly) @(posedge CLK); #1; end
        M1_WDATA = data; M1_WSTRB = strb; M1_WVALID = 1;
        for (int b = 0; b < 600 && !wOk; b++) begin @(negedge CLK); wOk = M1_WREADY; end
        @(posedge CLK); #1; M1_WVALID = 0;
      end
    join
    checkOutput("M1 AW handshake", {31'b0, awOk}, 32'd1);
    checkOutput("M1 W handshake", {31'b0, wOk}, 32'd1);
    writesIssued++;
    for (int b = 0; b < 600 && !ok; b++) begin
      M1_BREADY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      ok = M1_BVALID && M1_BREADY;
      if (!ok) begin @(posedge CLK); #1; end
    end
    checkOutput("M1 B handshake", {31'b0, ok}, 32'd1);
    if (ok) begin
      checkOutput("M1_BRESP", {30'b0, M1_BRESP}, {30'b0, respFunc(addr)});
      @(posedge CLK); #1;
    end
    M1_BREADY = 0; m1InB = 0;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = $urandom_range(0, 32'hFFFF);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Concurrent random traffic on both read masters and the write path
  task automatic applyStimulus();
    fork
      for (int i = 0; i < 30; i++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g > 0) begin repeat (g) @(posedge CLK); #1; end
        readMaster(M0_IDX, randAddr());
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1;
        readMaster(M1_IDX, randAddr());
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1;
        writeM1(randAddr(), $urandom, 4'($urandom_range(1, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end
    join
  endtask

  initial begin
    logic expOrder[3];
    logic ok;
    int awBefore;
    NRST = 0;
    M0_ARADDR = '0; M0_ARVALID = 0; M0_RREADY = 0;
    M1_ARADDR = '0; M1_ARVALID = 0; M1_RREADY = 0;
    M1_AWADDR = '0; M1_AWVALID = 0; M1_WDATA = '0; M1_WSTRB = '0; M1_WVALID = 0; M1_BREADY = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset VALID/READY/GNT", {19'b0, handshakeOutputs()}, 32'd0);
    @(posedge CLK); #1;
    NRST = 1;
    monOn = 1;
    repeat (2) @(posedge CLK); #1;

    readMaster(M0_IDX, 32'h100);

    // M1 issues two back-to-back reads against one pending M0 read
    order.delete();
    fork
      begin readMaster(M1_IDX, 32'h2000); readMaster(M1_IDX, 32'h2004); end
      readMaster(M0_IDX, 32'h100);
      begin @(posedge CLK); @(negedge CLK); checkOutput("GNT_M1 first conflict", {31'b0, GNT_M1}, 32'd1); end
    join
`ifdef ARB_ROUND_ROBIN_EN
    expOrder = '{M1_IDX, M0_IDX, M1_IDX};
`else
    expOrder = '{M1_IDX, M1_IDX, M0_IDX};
`endif
    checkOutput("conflict read count", order.size(), 32'd3);
    for (int i = 0; i < 3 && i < order.size(); i++)
      checkOutput($sformatf("conflict order[%0d]", i), {31'b0, order[i]}, {31'b0, expOrder[i]});

    // AW two cycles in, W five cycles in
    awBefore = awCount;
    fork
      writeM1(32'h0000_0440, 32'hDEAD_BEEF, 4'b0011, 2, 5);
      begin
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checkOutput("S_WVALID with late W", {31'b0, S_WVALID}, 32'd1);
      end
    join
    checkOutput("single AW per write", awCount - awBefore, 32'd1);

    readMaster(M1_IDX, 32'h2050);
    readMaster(M0_IDX, 32'h100);

    applyStimulus();
    repeat (5) @(posedge CLK); #1;
    monOn = 0;

    // Reset while a read response is stalled on RREADY
    M0_ARADDR = 32'h300; M0_ARVALID = 1; ok = 0;
    for (int b = 0; b < 600 && !ok; b++) begin @(negedge CLK); ok = M0_ARREADY; end
    checkOutput("pre-reset AR handshake", {31'b0, ok}, 32'd1);
    @(posedge CLK); #1;
    M0_ARVALID = 0;
    if (ok) arIssued++;
    ok = 0;
    for (int b = 0; b < 600 && !ok; b++) begin @(negedge CLK); ok = M0_RVALID; end
    checkOutput("pre-reset RVALID", {31'b0, ok}, 32'd1);
    @(posedge CLK); #1;
    NRST = 0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("mid-read reset outputs", {19'b0, handshakeOutputs()}, 32'd0);
    @(posedge CLK); #1;
    NRST = 1;
    @(posedge CLK); #1;
    readMaster(M0_IDX, 32'h100);

    checkOutput("slave AR count", arCount, arIssued);
    checkOutput("slave AW count", awCount, writesIssued);
    checkOutput("slave W count", wCount, writesIssued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
